keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/calc_pkg.sv | 72 +++++++
 rtl/key_sync.sv | 28 ++
 rtl/keypad_scanner.sv | 137 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, digit range, scanner FSM states
// and the keypad matrix helper functions.
package calc_pkg;

    localparam logic [3:0] DIGIT_MIN    = 4'd0;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] KEY_CLR      = 4'b1010;
    localparam logic [3:0] KEY_SUB      = 4'b1011;
    localparam logic [3:0] KEY_ADD      = 4'b1100;
    localparam logic [3:0] KEY_IGUAL    = 4'b1101;
    localparam logic [3:0] KEY_SAVE     = 4'b1110;
    localparam logic [3:0] KEY_RECOVERY = 4'b1111;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } scanState_t;

    function automatic logic [3:0] keyCode(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'b0001;
            4'b00_01: code = 4'b0010;
            4'b00_10: code = 4'b0011;
            4'b00_11: code = KEY_ADD;
            4'b01_00: code = 4'b0100;
            4'b01_01: code = 4'b0101;
            4'b01_10: code = 4'b0110;
            4'b01_11: code = KEY_SUB;
            4'b10_00: code = 4'b0111;
            4'b10_01: code = 4'b1000;
            4'b10_10: code = 4'b1001;
            4'b10_11: code = KEY_IGUAL;
            4'b11_00: code = KEY_RECOVERY;
            4'b11_01: code = 4'b0000;
            4'b11_10: code = KEY_SAVE;
            4'b11_11: code = KEY_CLR;
            default:  code = 4'b0000;
        endcase
        return code;
    endfunction

    // Rows are active-low; the lowest-numbered pressed row wins.
    function automatic logic [1:0] lowestLowRow(input logic [3:0] rowPat);
        logic [1:0] idx;
        if (!rowPat[0]) begin
            idx = 2'd0;
        end else if (!rowPat[1]) begin
            idx = 2'd1;
        end else if (!rowPat[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] colDrive(input logic [1:0] colIdx);
        logic [3:0] drive;
        case (colIdx)
            2'd0:    drive = 4'b1110;
            2'd1:    drive = 4'b1101;
            2'd2:    drive = 4'b1011;
            2'd3:    drive = 4'b0111;
            default: drive = 4'b1110;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-stage synchronizer for asynchronous inputs; idles at all-ones so a
// released active-low keypad reads as "no key" straight out of reset.
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             clearIn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] syncMeta_r;
    logic [WIDTH-1:0] syncOut_r;

    // Two flop stages, forced to the idle level on clear.
    always_ff @(posedge Clock) begin
        if (clearIn) begin
            syncMeta_r <= '1;
            syncOut_r  <= '1;
        end else begin
            syncMeta_r <= d;
            syncOut_r  <= syncMeta_r;
        end
    end

    assign q = syncOut_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce, producing a one-cycle
// ready pulse and a held key code for the downstream operation block.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       Clock,
    input  logic       clearIn,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] tecla,
    output logic       ready,
    output logic       keyHeld
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DWELL_ONE  = DIV_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);

    logic [3:0]       rowsSync_s;
    logic [1:0]       nextCol_s;
    scanState_t       state_r;
    logic [1:0]       colIdx_r;
    logic [DIV_W-1:0] dwellCnt_r;
    logic [DEB_W-1:0] debCnt_r;
    logic [3:0]       rowPat_r;
    logic [1:0]       rowIdx_r;
    logic [3:0]       cols_r;
    logic [3:0]       tecla_r;
    logic             ready_r;
    logic             keyHeld_r;

    key_sync #(.WIDTH(4)) uRowSync (
        .Clock   (Clock),
        .clearIn (clearIn),
        .d       (rows),
        .q       (rowsSync_s)
    );

    assign nextCol_s = colIdx_r + 2'd1;

    // Scanner FSM; the debounce counter is shared between press and release
    // and never runs past its terminal value, so it cannot wrap.
    always_ff @(posedge Clock) begin
        if (clearIn) begin
            state_r    <= SCAN;
            colIdx_r   <= 2'd0;
            dwellCnt_r <= '0;
            debCnt_r   <= '0;
            rowPat_r   <= 4'b1111;
            rowIdx_r   <= 2'd0;
            cols_r     <= 4'b1110;
            tecla_r    <= 4'b0000;
            ready_r    <= 1'b0;
            keyHeld_r  <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                SCAN: begin
                    if (dwellCnt_r >= DWELL_LAST) begin
                        dwellCnt_r <= '0;
                        if (rowsSync_s != 4'b1111) begin
                            rowPat_r <= rowsSync_s;
                            rowIdx_r <= lowestLowRow(rowsSync_s);
                            debCnt_r <= '0;
                            state_r  <= DEBOUNCE;
                        end else begin
                            colIdx_r <= nextCol_s;
                            cols_r   <= colDrive(nextCol_s);
                        end
                    end else begin
                        dwellCnt_r <= dwellCnt_r + DWELL_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (rowsSync_s == rowPat_r) begin
                        if (debCnt_r >= DEB_LAST) begin
                            debCnt_r  <= '0;
                            tecla_r   <= keyCode(rowIdx_r, colIdx_r);
                            ready_r   <= 1'b1;
                            keyHeld_r <= 1'b1;
                            state_r   <= EMIT;
                        end else begin
                            debCnt_r <= debCnt_r + DEB_ONE;
                        end
                    end else begin
                        // Glitch or bounce: give up on this column and move on.
                        debCnt_r   <= '0;
                        dwellCnt_r <= '0;
                        colIdx_r   <= nextCol_s;
                        cols_r     <= colDrive(nextCol_s);
                        state_r    <= SCAN;
                    end
                end
                EMIT: begin
                    debCnt_r <= '0;
                    state_r  <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (rowsSync_s == 4'b1111) begin
                        if (debCnt_r >= DEB_LAST) begin
                            debCnt_r   <= '0;
                            keyHeld_r  <= 1'b0;
                            dwellCnt_r <= '0;
                            colIdx_r   <= nextCol_s;
                            cols_r     <= colDrive(nextCol_s);
                            state_r    <= SCAN;
                        end else begin
                            debCnt_r <= debCnt_r + DEB_ONE;
                        end
                    end else begin
                        debCnt_r <= '0;
                    end
                end
                default: begin
                    state_r    <= SCAN;
                    colIdx_r   <= 2'd0;
                    dwellCnt_r <= '0;
                    debCnt_r   <= '0;
                    cols_r     <= 4'b1110;
                    keyHeld_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cols    = cols_r;
    assign tecla   = tecla_r;
    assign ready   = ready_r;
    assign keyHeld = keyHeld_r;

endmodule
